lsu_align: RTL and testbench
============================

# lsu_align

Load/store alignment unit sitting directly upstream of the byte-enabled data memory in the SimpleARM datapath. It accepts byte, halfword and word requests at any byte address. It generates per-lane byte enables and lane-shifted write data, and splits accesses that cross a word boundary into two sequential aligned memory cycles. Load data is merged, extended and returned with a one-cycle registered response.

## Interface
Parameters:
- none; address and data are fixed at 32 bits.

Ports:
- Clock and reset: one clock, `clk`; reset is asynchronous and active-low, `reset_n`.
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high exactly when state is IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  sign-extend load result (ignored for word and store)
- req_addr  in  32  byte address, any alignment
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse (loads and stores)
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  reserved size flagged with resp_valid
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte-lane enables
- mem_a  out  32  memory address, bits [1:0] always 00
- mem_wd  out  32  lane-shifted write data
- mem_rd  in  32  memory read data, combinational from mem_a

## Operation
- FSM states: IDLE, ACC0, ACC1. A request is accepted on an edge where req_valid && req_ready. Accepting latches we, size, signed, addr and wdata, then moves to ACC0.
- Let o = addr[1:0], n = bytes (1/2/4), m = 4'b0001/0011/1111.
- ACC0 drives:
  - mem_a = {addr[31:2],2'b00}
  - mem_be = (m<<o)&4'hF
  - mem_wd = wdata<<(8*o)
  - mem_we = we
- ACC0 with o+n>4 (split): captures mem_rd into rd0 and goes to ACC1. Otherwise it goes to IDLE.
- ACC1 drives:
  - mem_a = {addr[31:2],2'b00}+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000)
  - mem_be = m>>(4-o)
  - mem_wd = wdata>>(8*(4-o))
  - mem_we = we
- ACC1 always goes to IDLE.
- Load result: take {rd1,rd0}>>(8*o), where rd1 = mem_rd in ACC1 (0 if not split) and rd0 = mem_rd in ACC0. Keep the low n bytes, then sign-extend if req_signed, else zero-extend.
- On leaving the final access state, resp_valid is registered to 1 for exactly one cycle, along with resp_rdata.
- Reserved size: no memory cycle; mem_we=0, mem_be=0. Goes to IDLE with resp_valid=1, resp_err=1, resp_rdata=0.
- In IDLE: mem_we=0, mem_be=0, mem_a/mem_wd hold last latched values.
- req_valid while not IDLE is ignored; upstream must hold the request.
- Asynchronous reset, including mid-split: state goes to IDLE and every output drops immediately. A first-half store write already committed at an earlier edge is not undone.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_we 0, mem_be 0, mem_a 0, mem_wd 0; latched request registers 0.
- Aligned access: accept at edge E0, ACC0 cycle, memory write/capture at E1, resp_valid high in the cycle after E1.
- Split access: accept at E0, ACC0 at E1, ACC1 at E2, resp_valid high after E2.
- Throughput: a new request may be accepted in the same cycle resp_valid is high, since the state is IDLE. Back-to-back aligned rate is one request per 2 cycles; split rate is one per 3 cycles.
- Memory writes occur on the rising clk edge ending ACC0/ACC1. mem_rd is sampled at that same edge.

## Structure
- Package lsu_pkg holds:
  - size_e enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD)
  - state_e enum (IDLE, ACC0, ACC1)
  - function size_mask(size_e) returning m
- One combinational sub-module, lsu_lane_gen: inputs offset, size, phase and wdata; outputs be and shifted wd for either phase.
- lsu_align holds the FSM, request/rd0 registers, load merge/extend logic and response registers.

## Test plan
- Word store at 0x100, data 0xDEADBEEF: one ACC0 cycle with mem_a=0x100, be=1111, wd=0xDEADBEEF. resp_valid 2 cycles after accept, resp_rdata=0.
- Signed byte load at 0x102 with mem[0x100]=0x00800000: single access with be=0100. resp_rdata=0xFFFFFF80. The same load unsigned returns 0x00000080.
- Word store at 0x103, data 0x11223344:
  - ACC0: mem_a=0x100, be=1000, wd=0x44000000.
  - ACC1: mem_a=0x104, be=0111, wd=0x00112233.
  - resp_valid 3 cycles after accept.
- Signed half load at 0xFFFFFFFF with mem[0xFFFFFFFC]=0xAB000000 and mem[0x0]=0x000000CD: ACC1 mem_a=0x00000000, resp_rdata=0xFFFFCDAB.
- Assert reset_n low during ACC1 of a split store: outputs drop to reset values immediately, the second-half write does not occur, and req_ready=1 after release.
- req_size=11 at 0x200: no mem_we/mem_be activity. resp_valid=1, resp_err=1, resp_rdata=0. A following aligned request is accepted in the resp_valid cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store alignment unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2
    } state_e;

    function automatic logic [3:0] size_mask(size_e size);
        case (size)
            SZ_BYTE: size_mask = 4'b0001;
            SZ_HALF: size_mask = 4'b0011;
            SZ_WORD: size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    endfunction

    // An access spills into the next word when offset + bytes exceeds 4.
    function automatic logic crosses_word(logic [1:0] offset, size_e size);
        case (size)
            SZ_HALF: crosses_word = (offset == 2'd3);
            SZ_WORD: crosses_word = (offset != 2'd0);
            default: crosses_word = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_gen.sv
// Byte-enable and write-data lane steering for the first (phase 0) or
// second (phase 1) aligned memory cycle of an access.
module lsu_lane_gen
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  size_e       size,
    input  logic        phase,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wd
);

    logic [3:0] m;
    logic [7:0] be_wide;
    logic [5:0] up_sh;
    logic [5:0] dn_sh;

    // The upper nibble of m<<o is exactly m>>(4-o), the second-word lanes.
    always_comb begin
        m       = size_mask(size);
        up_sh   = {1'b0, offset, 3'b000};
        dn_sh   = 6'd32 - up_sh;
        be_wide = {4'b0000, m} << offset;
        if (!phase) begin
            be = be_wide[3:0];
            wd = wdata << up_sh;
        end else begin
            be = be_wide[7:4];
            wd = wdata >> dn_sh;
        end
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: latches a request, runs one or two aligned
// memory cycles, merges/extends load data and returns a registered response.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    state_e      state;
    logic        r_we;
    logic        r_signed;
    size_e       r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] rd0;

    logic        phase;
    logic        active;
    logic        split;
    logic        rsvd;
    logic [3:0]  lane_be;
    logic [31:0] lane_wd;
    logic [31:0] word_a;
    logic [31:0] rd_hi;
    logic [31:0] rd_lo;
    logic [63:0] merged;
    logic [31:0] low;
    logic [31:0] ld_data;
    logic [31:0] fin_rdata;

    lsu_lane_gen u_lane_gen (
        .offset (r_addr[1:0]),
        .size   (r_size),
        .phase  (phase),
        .wdata  (r_wdata),
        .be     (lane_be),
        .wd     (lane_wd)
    );

    always_comb begin
        phase     = (state == ACC1);
        active    = (state != IDLE);
        rsvd      = (r_size == SZ_RSVD);
        split     = crosses_word(r_addr[1:0], r_size);
        word_a    = {r_addr[31:2], 2'b00};
        req_ready = (state == IDLE);
        mem_a     = phase ? word_a + 32'd4 : word_a;
        mem_be    = active ? lane_be : 4'b0000;
        mem_we    = active && r_we && !rsvd;
        mem_wd    = lane_wd;

        // Second word supplies the high half only when the access was split.
        rd_hi  = phase ? mem_rd : '0;
        rd_lo  = phase ? rd0 : mem_rd;
        merged = {rd_hi, rd_lo} >> {r_addr[1:0], 3'b000};
        low    = merged[31:0];
        case (r_size)
            SZ_BYTE: ld_data = {{24{r_signed & low[7]}}, low[7:0]};
            SZ_HALF: ld_data = {{16{r_signed & low[15]}}, low[15:0]};
            default: ld_data = low;
        endcase
        fin_rdata = (r_we || rsvd) ? '0 : ld_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            r_we       <= 1'b0;
            r_signed   <= 1'b0;
            r_size     <= SZ_BYTE;
            r_addr     <= '0;
            r_wdata    <= '0;
            rd0        <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_signed <= req_signed;
                        r_size   <= size_e'(req_size);
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        state    <= ACC0;
                    end
                end
                ACC0: begin
                    if (split && !rsvd) begin
                        rd0   <= mem_rd;
                        state <= ACC1;
                    end else begin
                        state      <= IDLE;
                        resp_valid <= 1'b1;
                        resp_rdata <= fin_rdata;
                        resp_err   <= rsvd;
                    end
                end
                ACC1: begin
                    state      <= IDLE;
                    resp_valid <= 1'b1;
                    resp_rdata <= fin_rdata;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Self-checking bench for lsu_align with a byte-lane memory model and a
// response scoreboard.
module tb_lsu_align;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    exp_t        sbq[$];
    int          checks;
    int          failures;
    logic [31:0] mem [256];

    lsu_align dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[9:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) mem[mem_a[9:2]][8*i +: 8] <= mem_wd[8*i +: 8];
        end
    end

    // Called just after a falling edge with the unit idle; returns at the
    // falling edge of the first access cycle.
    task automatic send(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input logic expect_resp);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        if (expect_resp) sbq.push_back('{exp_rdata, exp_err});
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        exp_t e;
        lat = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat < 0) begin
            failures++;
            $display("FAIL resp_timeout: no resp_valid within 6 cycles");
        end else begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL resp_unexpected: got rdata=%h err=%b, none expected", resp_rdata, resp_err);
            end else begin
                e = sbq.pop_front();
                if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                    failures++;
                    $display("FAIL resp_data: got rdata=%h err=%b, expected rdata=%h err=%b",
                             resp_rdata, resp_err, e.rdata, e.err);
                end
            end
        end
    endtask

    task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rdata);
        int lat;
        send(we, sz, sg, a, wd, exp_rdata, 1'b0, 1'b1);
        wait_resp(lat);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b1000 ||
            resp_rdata !== 32'h0 || mem_be !== 4'h0 || mem_a !== 32'h0 || mem_wd !== 32'h0) begin
            failures++;
            $display("FAIL reset_values: ready=%b rv=%b err=%b we=%b rdata=%h be=%b a=%h wd=%h, expected 1 0 0 0 0 0000 0 0",
                     req_ready, resp_valid, resp_err, mem_we, resp_rdata, mem_be, mem_a, mem_wd);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_store;
        int lat;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL ws_ready: got %b expected 1", req_ready);
        end
        send(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        checks++;
        if (mem_we !== 1'b1 || mem_a !== 32'h100 || mem_be !== 4'b1111 || mem_wd !== 32'hDEADBEEF || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL ws_acc0: we=%b a=%h be=%b wd=%h ready=%b, expected 1 00000100 1111 deadbeef 0",
                     mem_we, mem_a, mem_be, mem_wd, req_ready);
        end
        wait_resp(lat);
        checks++;
        if (lat !== 1) begin
            failures++; $display("FAIL ws_latency: got %0d expected 1", lat);
        end
        xact(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF);
    endtask

    task automatic test_byte_load;
        int lat;
        xact(1'b1, 2'b10, 1'b0, 32'h100, 32'h00800000, 32'h0);
        send(1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1);
        checks++;
        if (mem_we !== 1'b0 || mem_a !== 32'h100 || mem_be !== 4'b0100) begin
            failures++;
            $display("FAIL bl_acc0: we=%b a=%h be=%b, expected 0 00000100 0100", mem_we, mem_a, mem_be);
        end
        wait_resp(lat);
        checks++;
        if (lat !== 1) begin
            failures++; $display("FAIL bl_latency: got %0d expected 1", lat);
        end
        xact(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 32'h00000080);
    endtask

    task automatic test_split_store;
        int lat;
        xact(1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0);
        xact(1'b1, 2'b10, 1'b0, 32'h104, 32'h0, 32'h0);
        send(1'b1, 2'b10, 1'b0, 32'h103, 32'h11223344, 32'h0, 1'b0, 1'b1);
        checks++;
        if (mem_we !== 1'b1 || mem_a !== 32'h100 || mem_be !== 4'b1000 || mem_wd !== 32'h44000000) begin
            failures++;
            $display("FAIL ss_acc0: we=%b a=%h be=%b wd=%h, expected 1 00000100 1000 44000000", mem_we, mem_a, mem_be, mem_wd);
        end
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_a !== 32'h104 || mem_be !== 4'b0111 || mem_wd !== 32'h00112233 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL ss_acc1: we=%b a=%h be=%b wd=%h rv=%b, expected 1 00000104 0111 00112233 0",
                     mem_we, mem_a, mem_be, mem_wd, resp_valid);
        end
        wait_resp(lat);
        checks++;
        if (lat !== 1) begin
            failures++; $display("FAIL ss_latency: got %0d cycles after ACC1, expected 1", lat);
        end
        xact(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h44000000);
        xact(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'h00112233);
        xact(1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 32'h11223344);
    endtask

    task automatic test_wrap_load;
        int lat;
        xact(1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'hAB000000, 32'h0);
        xact(1'b1, 2'b10, 1'b0, 32'h00000000, 32'h000000CD, 32'h0);
        send(1'b0, 2'b01, 1'b1, 32'hFFFFFFFF, 32'h0, 32'hFFFFCDAB, 1'b0, 1'b1);
        checks++;
        if (mem_a !== 32'hFFFFFFFC || mem_be !== 4'b1000) begin
            failures++; $display("FAIL wrap_acc0: a=%h be=%b, expected fffffffc 1000", mem_a, mem_be);
        end
        @(negedge clk);
        checks++;
        if (mem_a !== 32'h00000000 || mem_be !== 4'b0001) begin
            failures++; $display("FAIL wrap_acc1: a=%h be=%b, expected 00000000 0001", mem_a, mem_be);
        end
        wait_resp(lat);
    endtask

    task automatic test_reset_midsplit;
        xact(1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0);
        xact(1'b1, 2'b10, 1'b0, 32'h104, 32'hAAAAAAAA, 32'h0);
        send(1'b1, 2'b10, 1'b0, 32'h103, 32'h11223344, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_a !== 32'h104) begin
            failures++; $display("FAIL rst_acc1: we=%b a=%h, expected 1 00000104", mem_we, mem_a);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b1000 ||
            resp_rdata !== 32'h0 || mem_be !== 4'h0 || mem_a !== 32'h0 || mem_wd !== 32'h0) begin
            failures++;
            $display("FAIL rst_async: ready=%b rv=%b err=%b we=%b rdata=%h be=%b a=%h wd=%h, expected 1 0 0 0 0 0000 0 0",
                     req_ready, resp_valid, resp_err, mem_we, resp_rdata, mem_be, mem_a, mem_wd);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++; $display("FAIL rst_release: ready=%b rv=%b, expected 1 0", req_ready, resp_valid);
        end
        xact(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'hAAAAAAAA);
        xact(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h44000000);
    endtask

    task automatic test_reserved;
        int lat;
        send(1'b1, 2'b11, 1'b0, 32'h200, 32'h12345678, 32'h0, 1'b1, 1'b1);
        checks++;
        if (mem_we !== 1'b0 || mem_be !== 4'b0000) begin
            failures++; $display("FAIL rsvd_mem: we=%b be=%b, expected 0 0000", mem_we, mem_be);
        end
        wait_resp(lat);
        checks++;
        if (lat !== 1 || req_ready !== 1'b1) begin
            failures++; $display("FAIL rsvd_resp_cycle: lat=%0d ready=%b, expected 1 1", lat, req_ready);
        end
        send(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h44000000, 1'b0, 1'b1);
        wait_resp(lat);
        checks++;
        if (lat !== 1) begin
            failures++; $display("FAIL rsvd_followup_latency: got %0d expected 1", lat);
        end
    endtask

    task automatic test_back_to_back;
        vec_t v[$];
        int lat;
        v.push_back('{1'b1, 2'b10, 1'b0, 32'h100, 32'h8899AABB, 32'h0,        1});
        v.push_back('{1'b1, 2'b10, 1'b0, 32'h104, 32'h00000077, 32'h0,        1});
        v.push_back('{1'b0, 2'b01, 1'b0, 32'h101, 32'h0,        32'h000099AA, 1});
        v.push_back('{1'b0, 2'b01, 1'b1, 32'h101, 32'h0,        32'hFFFF99AA, 1});
        v.push_back('{1'b0, 2'b00, 1'b0, 32'h103, 32'h0,        32'h00000088, 1});
        v.push_back('{1'b0, 2'b01, 1'b1, 32'h102, 32'h0,        32'hFFFF8899, 1});
        v.push_back('{1'b0, 2'b01, 1'b1, 32'h103, 32'h0,        32'h00007788, 2});
        v.push_back('{1'b0, 2'b10, 1'b0, 32'h102, 32'h0,        32'h00778899, 2});
        v.push_back('{1'b1, 2'b00, 1'b0, 32'h101, 32'hFFFFFF5A, 32'h0,        1});
        v.push_back('{1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'h88995ABB, 1});
        foreach (v[k]) begin
            send(v[k].we, v[k].sz, v[k].sg, v[k].a, v[k].wd, v[k].exp, 1'b0, 1'b1);
            wait_resp(lat);
            checks++;
            if (lat !== v[k].lat) begin
                failures++;
                $display("FAIL b2b_latency[%0d]: got %0d expected %0d", k, lat, v[k].lat);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_word_store();
        test_byte_load();
        test_split_store();
        test_wrap_load();
        test_reset_midsplit();
        test_reserved();
        test_back_to_back();
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d responses outstanding, expected 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
